fp_issue_ctrl: RTL and testbench
================================

FP_ISSUE_CTRL -- requirements
Module: fp_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, which is the maximum number of WAIT cycles allowed for an FPU result before the operation is aborted.
REQ-002 SHALL have ports (name / direction / width / meaning), as listed below.
- clk_i / in / 1 / the single clock. All state updates on its rising edge.
- rst_i / in / 1 / asynchronous, active-high reset.
- dec_valid_i / in / 1 / the core presents an FP instruction. The core holds it stable while stall_o is high.
- dec_instr_i / in / 32 / FP instruction word.
- dec_rs1_i / in / 32 / integer rs1 operand, used for moves and converts.
- flush_i / in / 1 / core pipeline flush.
- stall_o / out / 1 / stalls the core issue stage.
- fpu_valid_o / out / 1 / drives the FPU wrapper core_valid input.
- fpu_instr_o / out / 32 / registered instruction sent to the FPU.
- fpu_rs1_o / out / 32 / registered rs1 sent to the FPU.
- fpu_in_ready_i / in / 1 / FPU input ready.
- fpu_flush_o / out / 1 / FPU flush.
- fpu_out_valid_i / in / 1 / FPU result valid.
- fpu_out_ready_o / out / 1 / FPU result ready.
- fpu_result_i / in / 32 / FPU result.
- fpu_int_wr_i / in / 1 / the decoded instruction writes the integer register file.
- wb_valid_o / out / 1 / writeback request.
- wb_ready_i / in / 1 / writeback port accepts the request.
- wb_data_o / out / 32 / writeback data.
- wb_rd_o / out / 5 / destination register.
- wb_int_o / out / 1 / 1 = integer RF destination, 0 = FP RF destination.
- timeout_o / out / 1 / one-cycle abort pulse.

Function
REQ-003 SHALL implement the FSM states IDLE, ISSUE, WAIT and WB.
REQ-004 In IDLE, when dec_valid_i=1 and flush_i=0, the block SHALL do the following and go to ISSUE:
- register dec_instr_i and dec_rs1_i;
- register rd = dec_instr_i[11:7].
REQ-005 In ISSUE, fpu_valid_o SHALL be 1, and fpu_instr_o and fpu_rs1_o SHALL hold the registered values.
REQ-006 In ISSUE, when fpu_in_ready_i=1, the block SHALL capture fpu_int_wr_i as the int flag and go to WAIT. fpu_valid_o SHALL stay 1 until that accept.
REQ-007 In WAIT, fpu_out_ready_o SHALL be 1. On fpu_out_valid_i=1 the block SHALL capture fpu_result_i into the result register and go to WB.
REQ-008 fpu_out_ready_o SHALL be 0 in every state other than WAIT.
REQ-009 In WB, wb_valid_o SHALL be 1 and wb_data_o/wb_rd_o/wb_int_o SHALL hold stable until wb_ready_i=1, at which point the block SHALL return to IDLE.
REQ-010 stall_o SHALL be 1 whenever dec_valid_i=1, except:
- in the cycle WB completes (wb_ready_i=1);
- in a cycle with flush_i=1.
REQ-011 Minimum latency with all ready inputs high SHALL be as follows:
- dec_valid_i at cycle 0;
- fpu_valid_o at cycle 1;
- result capture at cycle 2;
- wb_valid_o and stall_o release at cycle 3;
- back in IDLE at cycle 4.
REQ-012 A cycle counter SHALL clear on entry to WAIT and increment on each WAIT cycle without fpu_out_valid_i.
REQ-013 When the counter reaches TIMEOUT_CYCLES-1 without a result, the block SHALL, in the same cycle:
- pulse timeout_o for one cycle;
- pulse fpu_flush_o for one cycle;
- release stall_o;
- go to IDLE with no writeback.
REQ-014 When flush_i=1 in ISSUE or WAIT, the block SHALL pulse fpu_flush_o for one cycle and go to IDLE. A result arriving in that same cycle SHALL be discarded.
REQ-015 When flush_i=1 in WB, the block SHALL drop wb_valid_o in that same cycle and go to IDLE. fpu_flush_o SHALL NOT be asserted.
REQ-016 When flush_i=1 in IDLE, the block SHALL NOT accept dec_valid_i.
REQ-017 If flush_i and fpu_out_valid_i are both 1, flush SHALL win. If flush_i and wb_ready_i are both 1, flush SHALL win and the writeback SHALL NOT be counted.
REQ-018 fpu_flush_o and timeout_o SHALL be registered pulses, never asserted for two consecutive cycles.
REQ-019 The block SHALL have at most one instruction in flight. A new dec_valid_i SHALL be accepted only in IDLE.

Reset
REQ-020 While rst_i=1 (asynchronous, active-high), the FSM SHALL be in IDLE and the outputs SHALL be:
- fpu_valid_o=0, fpu_out_ready_o=0, fpu_flush_o=0;
- wb_valid_o=0, timeout_o=0, stall_o=0;
- all data registers at 0, counter at 0.
REQ-021 A reset asserted mid-operation SHALL abandon the instruction with no writeback and no flush pulse. After rst_i falls, the first acceptance SHALL be possible in the next cycle.

Verification
REQ-022 Bench scenario, back-to-back ready path:
- stimulus: FADD.S with rd=5; fpu_in_ready_i=1; result 0x40400000 on cycle 2; wb_ready_i=1;
- response: wb_valid_o at cycle 3 with wb_data_o=0x40400000, wb_rd_o=5, wb_int_o=0; stall_o low at cycle 3.
REQ-023 Bench scenario, backpressure:
- stimulus: fpu_in_ready_i low for 3 cycles, then wb_ready_i low for 2 cycles;
- response: fpu_valid_o held for 4 cycles; wb outputs stable for 3 cycles; exactly one writeback.
REQ-024 Bench scenario, integer destination:
- stimulus: FMV.X.W with rd=10, fpu_int_wr_i=1, dec_rs1_i ignored by the FPU;
- response: wb_int_o=1, wb_rd_o=10.
REQ-025 Bench scenario, timeout:
- stimulus: TIMEOUT_CYCLES=8, no fpu_out_valid_i;
- response: timeout_o and fpu_flush_o pulse once on the 8th WAIT cycle; no wb_valid_o; state returns to IDLE.
REQ-026 Bench scenario, flush:
- stimulus: flush_i in WAIT coincident with fpu_out_valid_i;
- response: fpu_flush_o pulses once; no writeback; the next instruction completes normally.
REQ-027 Bench scenario, reset in WB:
- stimulus: rst_i asserted in WB;
- response: wb_valid_o=0 immediately (asynchronous); all outputs at their reset values.

Source files
------------

// File: rtl/fp_issue_ctrl.sv
// Single-entry issue controller between the core decode stage and an FPU wrapper.
// Carries one FP instruction through issue, result wait (with abort timeout) and writeback.
module fp_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dec_valid_i,
    input  logic [31:0] dec_instr_i,
    input  logic [31:0] dec_rs1_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        fpu_valid_o,
    output logic [31:0] fpu_instr_o,
    output logic [31:0] fpu_rs1_o,
    input  logic        fpu_in_ready_i,
    output logic        fpu_flush_o,
    input  logic        fpu_out_valid_i,
    output logic        fpu_out_ready_o,
    input  logic [31:0] fpu_result_i,
    input  logic        fpu_int_wr_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [31:0] wb_data_o,
    output logic [4:0]  wb_rd_o,
    output logic        wb_int_o,
    output logic        timeout_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_e;

    state_e             state_q,     state_d;
    logic [31:0]        instr_q,     instr_d;
    logic [31:0]        rs1_q,       rs1_d;
    logic [31:0]        result_q,    result_d;
    logic [4:0]         rd_q,        rd_d;
    logic               int_q,       int_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               fpu_flush_q, fpu_flush_d;
    logic               timeout_q,   timeout_d;
    logic               wb_done;
    logic               timeout_hit;

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        rs1_d       = rs1_q;
        result_d    = result_q;
        rd_d        = rd_q;
        int_d       = int_q;
        cnt_d       = cnt_q;
        fpu_flush_d = 1'b0;
        timeout_d   = 1'b0;
        wb_done     = 1'b0;
        timeout_hit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dec_valid_i && !flush_i) begin
                    instr_d = dec_instr_i;
                    rs1_d   = dec_rs1_i;
                    rd_d    = dec_instr_i[11:7];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (flush_i) begin
                    fpu_flush_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (fpu_in_ready_i) begin
                    int_d   = fpu_int_wr_i;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Flush beats a same-cycle result; a result on the last allowed cycle beats the timeout.
                if (flush_i) begin
                    fpu_flush_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (fpu_out_valid_i) begin
                    result_d = fpu_result_i;
                    state_d  = ST_WB;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    timeout_d   = 1'b1;
                    fpu_flush_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WB: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (wb_ready_i) begin
                    wb_done = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            rs1_q       <= '0;
            result_q    <= '0;
            rd_q        <= '0;
            int_q       <= 1'b0;
            cnt_q       <= '0;
            fpu_flush_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            rs1_q       <= rs1_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
            int_q       <= int_d;
            cnt_q       <= cnt_d;
            fpu_flush_q <= fpu_flush_d;
            timeout_q   <= timeout_d;
        end
    end

    // The core instruction is released when it retires, is flushed, or is abandoned on timeout.
    assign stall_o         = dec_valid_i && !rst_i && !flush_i && !wb_done && !timeout_hit;
    assign fpu_valid_o     = (state_q == ST_ISSUE);
    assign fpu_out_ready_o = (state_q == ST_WAIT);
    assign wb_valid_o      = (state_q == ST_WB) && !flush_i;
    assign fpu_instr_o     = instr_q;
    assign fpu_rs1_o       = rs1_q;
    assign wb_data_o       = result_q;
    assign wb_rd_o         = rd_q;
    assign wb_int_o        = int_q;
    assign fpu_flush_o     = fpu_flush_q;
    assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Randomized self-checking bench for fp_issue_ctrl: directed scenarios plus random
// handshake delays and flushes checked against a phase-arithmetic model.
module tb_fp_issue_ctrl;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        dec_valid_i = 1'b0;
    logic [31:0] dec_instr_i = '0;
    logic [31:0] dec_rs1_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_o;
    logic        fpu_valid_o;
    logic [31:0] fpu_instr_o;
    logic [31:0] fpu_rs1_o;
    logic        fpu_in_ready_i = 1'b0;
    logic        fpu_flush_o;
    logic        fpu_out_valid_i = 1'b0;
    logic        fpu_out_ready_o;
    logic [31:0] fpu_result_i = '0;
    logic        fpu_int_wr_i = 1'b0;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b0;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic        wb_int_o;
    logic        timeout_o;

    fp_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .dec_valid_i(dec_valid_i), .dec_instr_i(dec_instr_i), .dec_rs1_i(dec_rs1_i),
        .flush_i(flush_i), .stall_o(stall_o),
        .fpu_valid_o(fpu_valid_o), .fpu_instr_o(fpu_instr_o), .fpu_rs1_o(fpu_rs1_o),
        .fpu_in_ready_i(fpu_in_ready_i), .fpu_flush_o(fpu_flush_o),
        .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
        .fpu_result_i(fpu_result_i), .fpu_int_wr_i(fpu_int_wr_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
        .wb_rd_o(wb_rd_o), .wb_int_o(wb_int_o), .timeout_o(timeout_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Observations gathered by run_op for one instruction (cycle 0 = first dec_valid_i cycle).
    int          o_fv_n, o_fv_first, o_or_n, o_wbv_n, o_wb_first, o_wb_fire;
    int          o_to_n, o_to_cyc, o_fl_n, o_fl_cyc, o_stall_low;
    logic [31:0] o_instr, o_rs1, o_wb_data;
    logic [4:0]  o_wb_rd;
    logic        o_wb_int, o_wb_unstable, o_consec;

    // Plays core + FPU + writeback port for one instruction, then watches three idle cycles.
    task automatic run_op(input logic [31:0] instr, input logic [31:0] rs1, input logic intf,
                          input logic [31:0] result, input int d_in, input int d_out,
                          input int d_wb, input int flush_cyc);
        int   cyc = 0;
        int   tail = 0;
        bit   rel = 1'b0;
        logic v_fv, v_or, v_wb;
        logic prev_to = 1'b0;
        logic prev_fl = 1'b0;
        o_fv_n = 0; o_fv_first = -1; o_or_n = 0; o_wbv_n = 0; o_wb_first = -1; o_wb_fire = 0;
        o_to_n = 0; o_to_cyc = -1; o_fl_n = 0; o_fl_cyc = -1; o_stall_low = -1;
        o_instr = '0; o_rs1 = '0; o_wb_data = '0; o_wb_rd = '0; o_wb_int = 1'b0;
        o_wb_unstable = 1'b0; o_consec = 1'b0;
        dec_instr_i = instr; dec_rs1_i = rs1; fpu_int_wr_i = intf;
        while (tail < 3 && cyc < 200) begin
            dec_valid_i = !rel;
            flush_i = 1'b0; fpu_in_ready_i = 1'b0; fpu_out_valid_i = 1'b0; wb_ready_i = 1'b0;
            #1;
            v_fv = fpu_valid_o; v_or = fpu_out_ready_o; v_wb = wb_valid_o;
            flush_i         = !rel && (cyc == flush_cyc);
            fpu_in_ready_i  = v_fv && (o_fv_n == d_in);
            fpu_out_valid_i = v_or && (o_or_n == d_out);
            fpu_result_i    = fpu_out_valid_i ? result : $urandom;
            wb_ready_i      = v_wb && (o_wbv_n == d_wb);
            #1;
            if (fpu_valid_o) begin
                if (o_fv_n == 0) begin o_fv_first = cyc; o_instr = fpu_instr_o; o_rs1 = fpu_rs1_o; end
                o_fv_n++;
            end
            if (fpu_out_ready_o) o_or_n++;
            if (wb_valid_o) begin
                if (o_wbv_n == 0) begin
                    o_wb_first = cyc; o_wb_data = wb_data_o; o_wb_rd = wb_rd_o; o_wb_int = wb_int_o;
                end else if ({o_wb_data, o_wb_rd, o_wb_int} != {wb_data_o, wb_rd_o, wb_int_o}) begin
                    o_wb_unstable = 1'b1;
                end
                o_wbv_n++;
                if (wb_ready_i) o_wb_fire++;
            end
            if (timeout_o) begin if (prev_to) o_consec = 1'b1; o_to_n++; o_to_cyc = cyc; end
            if (fpu_flush_o) begin if (prev_fl) o_consec = 1'b1; o_fl_n++; o_fl_cyc = cyc; end
            prev_to = timeout_o; prev_fl = fpu_flush_o;
            if (!rel) begin
                if (!stall_o) begin rel = 1'b1; o_stall_low = cyc; end
            end else begin
                tail++;
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        dec_valid_i = 1'b0; flush_i = 1'b0; fpu_in_ready_i = 1'b0; fpu_out_valid_i = 1'b0; wb_ready_i = 1'b0;
        $display("op instr=%h d_in=%0d d_out=%0d d_wb=%0d flush_cyc=%0d -> wb_fires=%0d data=%h rd=%0d int=%0d flushes=%0d timeouts=%0d release=%0d",
                 instr, d_in, d_out, d_wb, flush_cyc, o_wb_fire, o_wb_data, o_wb_rd, o_wb_int, o_fl_n, o_to_n, o_stall_low);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; dec_valid_i = 1'b1; dec_instr_i = $urandom; dec_rs1_i = $urandom;
        fpu_in_ready_i = 1'b1; fpu_out_valid_i = 1'b1; wb_ready_i = 1'b1; fpu_int_wr_i = 1'b1;
        fpu_result_i = $urandom;
        repeat (3) @(posedge clk_i);
        #2;
        checks++; if ({fpu_valid_o, fpu_out_ready_o, fpu_flush_o, wb_valid_o, timeout_o, stall_o} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=000000", {fpu_valid_o, fpu_out_ready_o, fpu_flush_o, wb_valid_o, timeout_o, stall_o}); end
        checks++; if ({fpu_instr_o, fpu_rs1_o, wb_data_o, wb_rd_o, wb_int_o} !== 102'd0) begin
            failures++; $display("FAIL reset_data got=%h/%h/%h/%0d/%0d exp=0", fpu_instr_o, fpu_rs1_o, wb_data_o, wb_rd_o, wb_int_o); end
        dec_valid_i = 1'b0; fpu_in_ready_i = 1'b0; fpu_out_valid_i = 1'b0; wb_ready_i = 1'b0; fpu_int_wr_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        checks++; if ({fpu_valid_o, fpu_out_ready_o, wb_valid_o, stall_o} !== 4'b0) begin
            failures++; $display("FAIL reset_idle got=%b exp=0000", {fpu_valid_o, fpu_out_ready_o, wb_valid_o, stall_o}); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] instr = {7'b0000000, 5'd2, 5'd1, 3'b111, 5'd5, 7'b1010011};
        logic [31:0] rs1 = $urandom;
        run_op(instr, rs1, 1'b0, 32'h40400000, 0, 0, 0, -1);
        checks++; if (o_fv_first !== 1) begin failures++; $display("FAIL b2b_fpu_valid_cycle got=%0d exp=1", o_fv_first); end
        checks++; if (o_instr !== instr || o_rs1 !== rs1) begin
            failures++; $display("FAIL b2b_fpu_payload got=%h/%h exp=%h/%h", o_instr, o_rs1, instr, rs1); end
        checks++; if (o_wb_first !== 3) begin failures++; $display("FAIL b2b_wb_cycle got=%0d exp=3", o_wb_first); end
        checks++; if (o_wb_data !== 32'h40400000 || o_wb_rd !== 5'd5 || o_wb_int !== 1'b0) begin
            failures++; $display("FAIL b2b_wb_fields got=%h/%0d/%0d exp=40400000/5/0", o_wb_data, o_wb_rd, o_wb_int); end
        checks++; if (o_stall_low !== 3) begin failures++; $display("FAIL b2b_stall_release got=%0d exp=3", o_stall_low); end
        checks++; if (o_wb_fire !== 1 || o_wbv_n !== 1) begin
            failures++; $display("FAIL b2b_wb_count got=%0d/%0d exp=1/1", o_wb_fire, o_wbv_n); end
        checks++; if (o_or_n !== 1) begin failures++; $display("FAIL b2b_out_ready_cycles got=%0d exp=1", o_or_n); end
    endtask

    task automatic test_backpressure();
        logic [31:0] instr = $urandom;
        logic [31:0] res = $urandom;
        run_op(instr, $urandom, 1'b0, res, 3, 0, 2, -1);
        checks++; if (o_fv_n !== 4) begin failures++; $display("FAIL bp_fpu_valid_cycles got=%0d exp=4", o_fv_n); end
        checks++; if (o_wbv_n !== 3 || o_wb_unstable !== 1'b0) begin
            failures++; $display("FAIL bp_wb_hold got=%0d unstable=%0d exp=3 unstable=0", o_wbv_n, o_wb_unstable); end
        checks++; if (o_wb_fire !== 1) begin failures++; $display("FAIL bp_wb_count got=%0d exp=1", o_wb_fire); end
        checks++; if (o_wb_data !== res || o_stall_low !== 8) begin
            failures++; $display("FAIL bp_result got=%h@%0d exp=%h@8", o_wb_data, o_stall_low, res); end
    endtask

    task automatic test_int_dest();
        logic [31:0] instr = {7'b1110000, 5'd0, 5'd3, 3'b000, 5'd10, 7'b1010011};
        run_op(instr, 32'hDEADBEEF, 1'b1, 32'h3F800000, 1, 1, 0, -1);
        checks++; if (o_wb_int !== 1'b1 || o_wb_rd !== 5'd10) begin
            failures++; $display("FAIL int_dest got=int%0d/rd%0d exp=int1/rd10", o_wb_int, o_wb_rd); end
        checks++; if (o_wb_data !== 32'h3F800000 || o_wb_fire !== 1) begin
            failures++; $display("FAIL int_data got=%h x%0d exp=3f800000 x1", o_wb_data, o_wb_fire); end
        checks++; if (o_rs1 !== 32'hDEADBEEF) begin failures++; $display("FAIL int_rs1 got=%h exp=deadbeef", o_rs1); end
    endtask

    task automatic test_timeout();
        logic [31:0] res = $urandom;
        run_op($urandom, $urandom, 1'b0, $urandom, 0, 1000, 0, -1);
        checks++; if (o_or_n !== TO) begin failures++; $display("FAIL to_wait_cycles got=%0d exp=%0d", o_or_n, TO); end
        checks++; if (o_stall_low !== TO + 1) begin failures++; $display("FAIL to_stall_release got=%0d exp=%0d", o_stall_low, TO + 1); end
        checks++; if (o_to_n !== 1 || o_to_cyc !== TO + 2) begin
            failures++; $display("FAIL to_pulse got=%0d@%0d exp=1@%0d", o_to_n, o_to_cyc, TO + 2); end
        checks++; if (o_fl_n !== 1 || o_fl_cyc !== TO + 2) begin
            failures++; $display("FAIL to_flush_pulse got=%0d@%0d exp=1@%0d", o_fl_n, o_fl_cyc, TO + 2); end
        checks++; if (o_wbv_n !== 0) begin failures++; $display("FAIL to_no_wb got=%0d exp=0", o_wbv_n); end
        run_op($urandom, $urandom, 1'b0, res, 0, 0, 0, -1);
        checks++; if (o_wb_fire !== 1 || o_wb_data !== res || o_wb_first !== 3) begin
            failures++; $display("FAIL to_recover got=%0d %h@%0d exp=1 %h@3", o_wb_fire, o_wb_data, o_wb_first, res); end
    endtask

    task automatic test_flush();
        logic [31:0] res = $urandom;
        run_op($urandom, $urandom, 1'b0, $urandom, 0, 2, 0, 4);
        checks++; if (o_fl_n !== 1 || o_fl_cyc !== 5) begin
            failures++; $display("FAIL fl_wait_pulse got=%0d@%0d exp=1@5", o_fl_n, o_fl_cyc); end
        checks++; if (o_wbv_n !== 0 || o_stall_low !== 4 || o_to_n !== 0) begin
            failures++; $display("FAIL fl_wait_drop got=wb%0d rel%0d to%0d exp=wb0 rel4 to0", o_wbv_n, o_stall_low, o_to_n); end
        run_op($urandom, $urandom, 1'b0, res, 0, 0, 0, -1);
        checks++; if (o_wb_fire !== 1 || o_wb_data !== res) begin
            failures++; $display("FAIL fl_recover got=%0d %h exp=1 %h", o_wb_fire, o_wb_data, res); end
        run_op($urandom, $urandom, 1'b0, $urandom, 0, 0, 2, 4);
        checks++; if (o_fl_n !== 0 || o_wb_fire !== 0 || o_wbv_n !== 1 || o_stall_low !== 4) begin
            failures++; $display("FAIL fl_wb got=fl%0d fire%0d wbv%0d rel%0d exp=fl0 fire0 wbv1 rel4", o_fl_n, o_wb_fire, o_wbv_n, o_stall_low); end
        run_op($urandom, $urandom, 1'b0, $urandom, 0, 0, 0, 0);
        checks++; if (o_fv_n !== 0 || o_stall_low !== 0 || o_fl_n !== 0) begin
            failures++; $display("FAIL fl_idle got=fv%0d rel%0d fl%0d exp=fv0 rel0 fl0", o_fv_n, o_stall_low, o_fl_n); end
    endtask

    task automatic test_reset_in_wb();
        logic [31:0] i2 = $urandom;
        logic [31:0] r2 = $urandom;
        dec_valid_i = 1'b1; dec_instr_i = $urandom; dec_rs1_i = $urandom; flush_i = 1'b0;
        fpu_in_ready_i = 1'b1; fpu_out_valid_i = 1'b1; fpu_result_i = 32'h12345678; wb_ready_i = 1'b0;
        fpu_int_wr_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if (wb_valid_o !== 1'b1 || stall_o !== 1'b1) begin
            failures++; $display("FAIL rstwb_in_wb got=wb%0d stall%0d exp=wb1 stall1", wb_valid_o, stall_o); end
        #1; rst_i = 1'b1; #1;
        checks++; if ({fpu_valid_o, fpu_out_ready_o, fpu_flush_o, wb_valid_o, timeout_o, stall_o} !== 6'b0) begin
            failures++; $display("FAIL rstwb_async_ctrl got=%b exp=000000", {fpu_valid_o, fpu_out_ready_o, fpu_flush_o, wb_valid_o, timeout_o, stall_o}); end
        checks++; if ({fpu_instr_o, fpu_rs1_o, wb_data_o, wb_rd_o, wb_int_o} !== 102'd0) begin
            failures++; $display("FAIL rstwb_async_data got=%h/%h/%h/%0d/%0d exp=0", fpu_instr_o, fpu_rs1_o, wb_data_o, wb_rd_o, wb_int_o); end
        @(posedge clk_i); #1;
        checks++; if (fpu_flush_o !== 1'b0 || timeout_o !== 1'b0) begin
            failures++; $display("FAIL rstwb_no_pulse got=fl%0d to%0d exp=0", fpu_flush_o, timeout_o); end
        rst_i = 1'b0; dec_instr_i = i2; fpu_result_i = r2; wb_ready_i = 1'b1; #1;
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL rstwb_idle_stall got=%0d exp=1", stall_o); end
        @(posedge clk_i); #1;
        checks++; if (fpu_valid_o !== 1'b1 || fpu_instr_o !== i2) begin
            failures++; $display("FAIL rstwb_first_accept got=%0d %h exp=1 %h", fpu_valid_o, fpu_instr_o, i2); end
        @(posedge clk_i); @(posedge clk_i); #1;
        checks++; if (wb_valid_o !== 1'b1 || wb_data_o !== r2 || stall_o !== 1'b0) begin
            failures++; $display("FAIL rstwb_after got=wb%0d %h stall%0d exp=wb1 %h stall0", wb_valid_o, wb_data_o, stall_o, r2); end
        @(posedge clk_i); #1;
        dec_valid_i = 1'b0; fpu_in_ready_i = 1'b0; fpu_out_valid_i = 1'b0; wb_ready_i = 1'b0; #1;
        checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL rstwb_single_wb got=%0d exp=0", wb_valid_o); end
    endtask

    // Expected behaviour comes from where the flush cycle falls among the phases
    // IDLE(0) / ISSUE(1..1+d_in) / WAIT(..wait_end) / WB(..wb_end).
    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] instr = $urandom;
            logic [31:0] rs1 = $urandom;
            logic [31:0] res = $urandom;
            logic intf = 1'($urandom_range(0, 1));
            int d_in = int'($urandom_range(0, 3));
            int d_wb = int'($urandom_range(0, 3));
            bit to = ($urandom_range(0, 5) == 0);
            int d_out = to ? 1000 : int'($urandom_range(0, TO - 1));
            int wait_end = to ? (1 + d_in + TO) : (2 + d_in + d_out);
            int last = to ? wait_end : (wait_end + 1 + d_wb);
            int fc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, last)) : -1;
            int e_rel, e_fl, e_to, e_wb;
            if (fc < 0) begin
                e_rel = last; e_fl = to ? 1 : 0; e_to = to ? 1 : 0; e_wb = to ? 0 : 1;
            end else if (fc == 0) begin
                e_rel = 0; e_fl = 0; e_to = 0; e_wb = 0;
            end else if (fc <= wait_end) begin
                e_rel = fc; e_fl = 1; e_to = 0; e_wb = 0;
            end else begin
                e_rel = fc; e_fl = 0; e_to = 0; e_wb = 0;
            end
            run_op(instr, rs1, intf, res, d_in, d_out, d_wb, fc);
            checks++; if (o_stall_low !== e_rel) begin
                failures++; $display("FAIL rnd%0d_release got=%0d exp=%0d", n, o_stall_low, e_rel); end
            checks++; if (o_wb_fire !== e_wb || o_fl_n !== e_fl || o_to_n !== e_to) begin
                failures++; $display("FAIL rnd%0d_events got=wb%0d fl%0d to%0d exp=wb%0d fl%0d to%0d", n, o_wb_fire, o_fl_n, o_to_n, e_wb, e_fl, e_to); end
            checks++; if (o_consec !== 1'b0 || o_wb_unstable !== 1'b0) begin
                failures++; $display("FAIL rnd%0d_pulse_shape got=consec%0d unstable%0d exp=0/0", n, o_consec, o_wb_unstable); end
            if (e_fl == 1) begin
                checks++; if (o_fl_cyc !== e_rel + 1) begin
                    failures++; $display("FAIL rnd%0d_flush_cycle got=%0d exp=%0d", n, o_fl_cyc, e_rel + 1); end
            end
            if (fc != 0) begin
                checks++; if (o_fv_first !== 1 || o_instr !== instr || o_rs1 !== rs1) begin
                    failures++; $display("FAIL rnd%0d_issue got=%0d %h/%h exp=1 %h/%h", n, o_fv_first, o_instr, o_rs1, instr, rs1); end
            end
            if (e_wb == 1) begin
                checks++; if (o_wb_data !== res || o_wb_rd !== instr[11:7] || o_wb_int !== intf || o_wb_first !== wait_end + 1) begin
                    failures++; $display("FAIL rnd%0d_wb got=%h/%0d/%0d@%0d exp=%h/%0d/%0d@%0d", n, o_wb_data, o_wb_rd, o_wb_int, o_wb_first,
                                         res, instr[11:7], intf, wait_end + 1); end
                checks++; if (o_fv_n !== d_in + 1 || o_or_n !== d_out + 1 || o_wbv_n !== d_wb + 1) begin
                    failures++; $display("FAIL rnd%0d_hold got=%0d/%0d/%0d exp=%0d/%0d/%0d", n, o_fv_n, o_or_n, o_wbv_n, d_in + 1, d_out + 1, d_wb + 1); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_int_dest();
        test_timeout();
        test_flush();
        test_reset_in_wb();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=time_limit exp=finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
